// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction-fetch stage of the 16-bit single-core processor. Owns the PC,
// drives the instruction-memory address, and buffers fetched words together
// with their PCs in a small prefetch FIFO so that a decode stall never drops
// an instruction. Supports a branch redirect (flushes the FIFO and reloads the
// PC) and stops fetching once the halt opcode has been enqueued.
//
// Ports:
//   clk          in   system clock, all state updates on the rising edge
//   rst          in   asynchronous, active-high reset
//   imem_addr    out  instruction-memory address (the PC register)
//   imem_rdata   in   instruction-memory read data, combinational from imem_addr
//   redirect     in   branch taken / PC redirect request from execute
//   redirect_pc  in   redirect target, sampled when redirect=1
//   id_ready     in   decode accepts the head entry this cycle
//   if_valid     out  FIFO non-empty, head entry presented
//   if_instr     out  head instruction, zero when if_valid=0
//   if_pc        out  PC of head instruction, zero when if_valid=0
//   fetch_halted out  halt opcode has been enqueued, fetching stopped
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int                  ADDR_W     = 5,
    parameter int                  DATA_W     = 16,
    parameter int                  DEPTH      = 2,
    parameter logic [ADDR_W-1:0]   RESET_PC   = '0,
    parameter logic [DATA_W-1:0]   HALT_INSTR = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              fetch_halted
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Control state
    logic [ADDR_W-1:0] pc_q,      pc_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic              halted_q,  halted_d;

    // FIFO storage (data only, never reset)
    logic [DATA_W-1:0] buf_instr_q [DEPTH];
    logic [DATA_W-1:0] buf_instr_d [DEPTH];
    logic [ADDR_W-1:0] buf_pc_q    [DEPTH];
    logic [ADDR_W-1:0] buf_pc_d    [DEPTH];

    logic pop;
    logic push;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // A pop at full frees the slot the push writes into on the same edge, so
    // a full queue still streams at one word per cycle.
    always_comb begin
        pop  = if_valid & id_ready;
        push = ~redirect & ~halted_q & ((count_q < DEPTH_C) | pop);
    end

    // -------------------------------------------------------------------------
    // Next-state for control
    // -------------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        halted_d = halted_q;

        if (redirect) begin
            // Flush wins over everything: a same-cycle pop was already shown
            // to decode, but its slot is simply discarded here.
            pc_d     = redirect_pc;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            halted_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                pc_d     = pc_q + ADDR_W'(1);
                if (imem_rdata == HALT_INSTR) begin
                    halted_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state for storage
    // -------------------------------------------------------------------------
    always_comb begin
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        if (push) begin
            buf_instr_d[wr_ptr_q] = imem_rdata;
            buf_pc_d[wr_ptr_q]    = pc_q;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_instr_q <= buf_instr_d;
        buf_pc_q    <= buf_pc_d;
    end

    // -------------------------------------------------------------------------
    // Outputs: registers and storage only, no path from id_ready/redirect
    // -------------------------------------------------------------------------
    always_comb begin
        imem_addr    = pc_q;
        fetch_halted = halted_q;
        if_valid     = (count_q != '0);
        if_instr     = '0;
        if_pc        = '0;
        if (if_valid) begin
            if_instr = buf_instr_q[rd_ptr_q];
            if_pc    = buf_pc_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// Testbench for instr_fetch_queue. A queue-based reference model tracks what
// the fetch stage should be presenting; outputs are compared on the falling
// edge after every rising edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2;
    localparam int MEM_N  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_ready;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              fetch_halted;

    logic [DATA_W-1:0] mem [MEM_N];
    assign imem_rdata = mem[imem_addr];

    instr_fetch_queue #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .RESET_PC  (5'd0),
        .HALT_INSTR(16'hFFFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .fetch_halted(fetch_halted)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of (pc, instr) pairs, the next fetch PC and
    // the halted flag.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    entry_t m_q[$];
    int     m_pc;
    bit     m_halted;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc     = 0;
        m_halted = 1'b0;
    endtask

    task automatic model_step(input bit redir, input int rpc, input bit rdy);
        int  sz;
        bit  pop;
        bit  push;
        sz  = m_q.size();
        pop = (sz > 0) && rdy;
        if (redir) begin
            m_q.delete();
            m_pc     = rpc;
            m_halted = 1'b0;
        end else begin
            push = !m_halted && ((sz < DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back('{pc: ADDR_W'(m_pc), instr: mem[m_pc]});
                if (mem[m_pc] == 16'hFFFF) m_halted = 1'b1;
                m_pc = (m_pc + 1) % MEM_N;
            end
        end
    endtask

    task automatic check_all(input string tag);
        bit          ev;
        logic [15:0] ei;
        logic [4:0]  ep;
        ev = (m_q.size() > 0);
        ei = ev ? m_q[0].instr : 16'h0;
        ep = ev ? m_q[0].pc : 5'd0;
        check({tag, ".if_valid"},     32'(if_valid),     32'(ev));
        check({tag, ".if_pc"},        32'(if_pc),        32'(ep));
        check({tag, ".if_instr"},     32'(if_instr),     32'(ei));
        check({tag, ".imem_addr"},    32'(imem_addr),    32'(m_pc));
        check({tag, ".fetch_halted"}, 32'(fetch_halted), 32'(m_halted));
    endtask

    // Drive inputs just after a falling edge, advance the model, let the
    // rising edge happen and compare on the next falling edge.
    task automatic cycle(input string tag, input bit redir, input int rpc, input bit rdy);
        redirect    = redir;
        redirect_pc = ADDR_W'(rpc);
        id_ready    = rdy;
        model_step(redir, rpc, rdy);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < MEM_N; i++) mem[i] = 16'h1000 + 16'(i);
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;
        model_reset();

        // Reset, then stream
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle("stream", 1'b0, 0, 1'b1);

        // Decode stall, then resume
        for (int i = 0; i < 5; i++) cycle("stall", 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) cycle("resume", 1'b0, 0, 1'b1);

        // Redirect while streaming at PC 4
        cycle("redir_setup", 1'b1, 0, 1'b1);
        for (int i = 0; i < 4; i++) cycle("to_pc4", 1'b0, 0, 1'b1);
        check("pc_before_redirect", 32'(imem_addr), 32'd4);
        cycle("redirect", 1'b1, 20, 1'b1);
        check("bubble_valid", 32'(if_valid), 32'd0);
        for (int i = 0; i < 3; i++) cycle("post_redir", 1'b0, 0, 1'b1);

        // Halt on opcode at PC 3
        mem[3] = 16'hFFFF;
        cycle("halt_redir", 1'b1, 0, 1'b1);
        for (int i = 0; i < 8; i++) cycle("halt", 1'b0, 0, 1'b1);
        check("halted_flag", 32'(fetch_halted), 32'd1);
        check("halted_pc", 32'(imem_addr), 32'd4);
        cycle("unhalt", 1'b1, 0, 1'b1);
        for (int i = 0; i < 3; i++) cycle("restart", 1'b0, 0, 1'b1);
        mem[3] = 16'h1003;

        // Halt while decode is stalled
        mem[6] = 16'hFFFF;
        cycle("halt_stall_redir", 1'b1, 5, 1'b0);
        for (int i = 0; i < 4; i++) cycle("halt_stall", 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) cycle("halt_drain", 1'b0, 0, 1'b1);
        mem[6] = 16'h1006;

        // PC wrap 31 -> 0
        cycle("wrap_redir", 1'b1, 30, 1'b1);
        for (int i = 0; i < 5; i++) cycle("wrap", 1'b0, 0, 1'b1);

        // Randomised traffic
        for (int i = 0; i < MEM_N; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            cycle("random",
                  $urandom_range(0, 15) == 0,
                  int'($urandom_range(0, MEM_N - 1)),
                  $urandom_range(0, 2) != 0);
        end

        // Async reset between edges while the queue is full
        for (int i = 0; i < MEM_N; i++) mem[i] = 16'h1000 + 16'(i);
        cycle("fill_redir", 1'b1, 9, 1'b0);
        for (int i = 0; i < 3; i++) cycle("fill", 1'b0, 0, 1'b0);
        check("full_valid", 32'(if_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        check_all("async_rst_hold");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle("after_rst", 1'b0, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
